// File: rtl/enc8x3_serializer.sv
// ---------------------------------------------------------------------------
// enc8x3_serializer
//   Sequential 8-to-3 encoder. It accepts an 8-bit request vector through a
//   valid/ready handshake. It then emits the 3-bit index of every set bit,
//   one index per output handshake, in priority order.
//
// Parameters
//   PRIORITY_HIGH : 1 = highest set index first, 0 = lowest set index first
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   request vector valid
//   in_ready   block can accept a vector (IDLE and not in reset)
//   req[7:0]   request vector, bit n = request for index n
//   out_valid  out_code valid
//   out_ready  consumer accepts out_code
//   out_code   index of the selected pending bit (0 when out_valid=0)
//   pending    number of bits still pending, including the one presented
//   out_last   (only with ENC8X3_LAST_EN) presented code is the final one
//
// Optional feature macro: ENC8X3_LAST_EN adds the out_last output.
// ---------------------------------------------------------------------------
module enc8x3_serializer #(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_code,
`ifdef ENC8X3_LAST_EN
  output logic       out_last,
`endif
  output logic [3:0] pending
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic [7:0] pend_reg, pend_next;
  logic [2:0] sel_idx;
  logic [3:0] pend_count;

  // Priority select over the pending bits. The loop direction decides
  // which set bit wins: the last match in iteration order is kept.
  generate
    if (PRIORITY_HIGH) begin : g_sel_high
      always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++)
          if (pend_reg[i]) sel_idx = 3'(i);
      end
    end else begin : g_sel_low
      always_comb begin
        sel_idx = 3'd0;
        for (int i = 7; i >= 0; i--)
          if (pend_reg[i]) sel_idx = 3'(i);
      end
    end
  endgenerate

  always_comb begin
    pend_count = 4'd0;
    for (int i = 0; i < 8; i++)
      pend_count = pend_count + {3'd0, pend_reg[i]};
  end

  // State and pending-vector registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pend_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    case (state_reg)
      IDLE: begin
        // An all-zero vector is consumed but produces nothing.
        if (in_valid && req != 8'd0) begin
          pend_next  = req;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (out_ready) begin
          pend_next = pend_reg & ~(8'd1 << sel_idx);
          // Only the presented bit remains, so the vector is done.
          if (pend_count == 4'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_reg == IDLE) && !rst;
    out_valid = (state_reg == BUSY);
    out_code  = out_valid ? sel_idx : 3'd0;
    pending   = pend_count;
`ifdef ENC8X3_LAST_EN
    out_last  = out_valid && (pend_count == 4'd1);
`endif
  end

endmodule

// File: tb/tb_enc8x3_serializer.sv
module tb_enc8x3_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] req;
  logic       out_ready;

  logic       in_ready_hi, out_valid_hi;
  logic [2:0] code_hi;
  logic [3:0] pend_hi;
  logic       in_ready_lo, out_valid_lo;
  logic [2:0] code_lo;
  logic [3:0] pend_lo;
`ifdef ENC8X3_LAST_EN
  logic       last_hi, last_lo;
`endif

  int total = 0;
  int bad   = 0;
  int hs    = 0;

  always #5 clk = ~clk;

  enc8x3_serializer #(.PRIORITY_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_hi),
    .req(req), .out_valid(out_valid_hi), .out_ready(out_ready),
    .out_code(code_hi),
`ifdef ENC8X3_LAST_EN
    .out_last(last_hi),
`endif
    .pending(pend_hi)
  );

  enc8x3_serializer #(.PRIORITY_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_lo),
    .req(req), .out_valid(out_valid_lo), .out_ready(out_ready),
    .out_code(code_lo),
`ifdef ENC8X3_LAST_EN
    .out_last(last_lo),
`endif
    .pending(pend_lo)
  );

  // One line per output transaction of the high-priority instance
  always @(posedge clk) begin
    if (!rst && out_valid_hi && out_ready) begin
      hs++;
      $display("xfer hi code=%0d pending=%0d", code_hi, pend_hi);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int exp_hi [3];
    int exp_lo [3];
    exp_hi = '{7, 5, 2};
    exp_lo = '{2, 5, 7};

    rst = 1'b1; in_valid = 1'b0; req = 8'd0; out_ready = 1'b0;
    tick();
    check("rst_in_ready", in_ready_hi, 0);
    check("rst_out_valid", out_valid_hi, 0);
    check("rst_pending", pend_hi, 0);
    check("rst_code", code_hi, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready_hi, 1);

    // Vector 1010_0100, both priority orders, out_ready held high
    in_valid = 1'b1; req = 8'hA4; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      check("a4_valid", out_valid_hi, 1);
      check("a4_in_ready", in_ready_hi, 0);
      check("a4_code_hi", code_hi, exp_hi[i]);
      check("a4_code_lo", code_lo, exp_lo[i]);
      check("a4_pending", pend_hi, 3 - i);
`ifdef ENC8X3_LAST_EN
      check("a4_last", last_hi, (i == 2) ? 1 : 0);
`endif
      tick();
    end
    check("a4_done_valid", out_valid_hi, 0);
    check("a4_done_in_ready", in_ready_hi, 1);
    check("a4_done_pending", pend_hi, 0);
    check("a4_done_code", code_hi, 0);

    // 8'hFF with out_ready toggling: every code held through its stall
    hs = 0;
    in_valid = 1'b1; req = 8'hFF; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; req = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check("ff_code", code_hi, 7 - i);
      check("ff_pending", pend_hi, 8 - i);
      tick();
      check("ff_stall_code", code_hi, 7 - i);
      check("ff_stall_pending", pend_hi, 8 - i);
      check("ff_stall_valid", out_valid_hi, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("ff_handshakes", hs, 8);
    check("ff_done_valid", out_valid_hi, 0);
    check("ff_done_pending", pend_hi, 0);
    check("ff_done_in_ready", in_ready_hi, 1);

    // Zero vector is dropped, then a single-bit vector
    in_valid = 1'b1; req = 8'h00;
    tick();
    check("zero_in_ready", in_ready_hi, 1);
    check("zero_valid", out_valid_hi, 0);
    tick();
    check("zero_valid2", out_valid_hi, 0);
    req = 8'h08;
    tick();
    in_valid = 1'b0; req = 8'h00;
    check("single_valid", out_valid_hi, 1);
    check("single_code", code_hi, 3);
    check("single_code_lo", code_lo, 3);
    check("single_pending", pend_hi, 1);
`ifdef ENC8X3_LAST_EN
    check("single_last", last_hi, 1);
`endif
    out_ready = 1'b1;
    tick();
    check("single_done_valid", out_valid_hi, 0);
    check("single_done_in_ready", in_ready_hi, 1);

    // New vector offered while BUSY must be ignored
    out_ready = 1'b0;
    in_valid = 1'b1; req = 8'h30;
    tick();
    req = 8'h01;
    check("busy_in_ready", in_ready_hi, 0);
    check("busy_code", code_hi, 5);
    check("busy_pending", pend_hi, 2);
    tick();
    check("busy_pending_hold", pend_hi, 2);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; req = 8'h00;
    check("busy_code2", code_hi, 4);
    check("busy_pending2", pend_hi, 1);
    tick();
    check("busy_done_valid", out_valid_hi, 0);
    tick();
    check("busy_no_code0", out_valid_hi, 0);

    // Reset in the middle of a vector
    in_valid = 1'b1; req = 8'hF0;
    tick();
    in_valid = 1'b0; req = 8'h00;
    check("mid_code1", code_hi, 7);
    tick();
    check("mid_code2", code_hi, 6);
    check("mid_pending2", pend_hi, 3);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid_hi, 0);
    check("mid_rst_pending", pend_hi, 0);
    check("mid_rst_in_ready", in_ready_hi, 0);
    check("mid_rst_code", code_hi, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready_hi, 1);
    in_valid = 1'b1; req = 8'h02;
    tick();
    in_valid = 1'b0; req = 8'h00;
    check("post_rst_code", code_hi, 1);
    check("post_rst_pending", pend_hi, 1);
    tick();
    check("post_rst_done", out_valid_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
